seg_scan_decoder: RTL and testbench

Receive-side counterpart of the team's multiplexed seven-segment driver. It watches the active-low anode lines (digit) and segment lines (display), waits for each scan phase to settle, and decodes the segment pattern back to a 4-bit value. It assembles the four values into a 16-bit word and compares each completed frame with the expected nums word. It sits in the debug path as a loopback self-check of the scoreboard display, with results on LEDs and the ILA.

---
 rtl/seg_pkg.sv | 68 ++++++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg_scan_decoder.sv | 158 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: active-low segment
// patterns {g..a}, active-low anode selects, and small helpers used when
// decoding and checking a captured frame.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] DIG0     = 4'b1110;
   localparam logic [3:0] DIG1     = 4'b1101;
   localparam logic [3:0] DIG2     = 4'b1011;
   localparam logic [3:0] DIG3     = 4'b0111;
   localparam logic [3:0] DIG_IDLE = 4'b1111;

   localparam logic [3:0] NIB_BLANK = 4'hF;

   // Registered copy of the observed scan lines.
   typedef struct packed {
      logic [3:0] digit;
      logic [6:0] display;
   } scan_t;

   // True when exactly one anode is driven low.
   function automatic logic dig_one_low(input logic [3:0] digit);
      logic result;
      case (digit)
         DIG0, DIG1, DIG2, DIG3: result = 1'b1;
         default:                result = 1'b0;
      endcase
      return result;
   endfunction

   // Position of the single low anode; only meaningful when dig_one_low().
   function automatic logic [1:0] dig_index(input logic [3:0] digit);
      logic [1:0] result;
      case (digit)
         DIG1:    result = 2'd1;
         DIG2:    result = 2'd2;
         DIG3:    result = 2'd3;
         default: result = 2'd0;
      endcase
      return result;
   endfunction

   // Decimal expectations need a lit, equal digit; anything A..F means the
   // driver was told to blank that position.
   function automatic logic nib_match(input logic [3:0] exp_nib,
                                      input logic [3:0] dec_nib,
                                      input logic       dec_blank);
      logic result;
      if (exp_nib <= 4'd9) begin
         result = (dec_nib == exp_nib) && !dec_blank;
      end else begin
         result = dec_blank;
      end
      return result;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern to nibble table. Blank reads as
// NIB_BLANK with is_blank; unknown patterns read as NIB_BLANK with is_err.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       is_blank,
   output logic       is_err
);

   // Pattern lookup; defaults cover every undecodable pattern.
   always_comb begin
      nibble   = NIB_BLANK;
      is_blank = 1'b0;
      is_err   = 1'b0;
      case (seg)
         SEG_0:     nibble = 4'd0;
         SEG_1:     nibble = 4'd1;
         SEG_2:     nibble = 4'd2;
         SEG_3:     nibble = 4'd3;
         SEG_4:     nibble = 4'd4;
         SEG_5:     nibble = 4'd5;
         SEG_6:     nibble = 4'd6;
         SEG_7:     nibble = 4'd7;
         SEG_8:     nibble = 4'd8;
         SEG_9:     nibble = 4'd9;
         SEG_BLANK: is_blank = 1'b1;
         default:   is_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback checker for the multiplexed seven-segment driver. Waits for each
// scan phase to settle, decodes it, assembles four digits into a frame and
// compares the finished frame against the word the driver is being fed.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int STALL_CYCLES  = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  digit,
   input  logic [6:0]  display,
   input  logic [15:0] expected,
   output logic [15:0] nums_out,
   output logic [3:0]  blank_mask,
   output logic        frame_valid,
   output logic        mismatch,
   output logic        seg_err,
   output logic        digit_err,
   output logic        stalled
);

   localparam int STALL_W = $clog2(STALL_CYCLES + 1);
   localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_CYCLES);
   localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);

   scan_t              in_raw;
   scan_t              in_q;
   logic               in_change;
   logic [7:0]         stable_cnt;
   logic               sampled;
   logic               settled;
   logic               dig_valid;
   logic               dig_multi;
   logic               sample;
   logic [1:0]         sample_idx;

   logic [3:0]         dec_nib;
   logic               dec_blank;
   logic               dec_err;

   logic [15:0]        frame_nib;
   logic [3:0]         frame_blank;
   logic [3:0]         collected;
   logic               frame_done;
   logic [3:0]         nib_miss;

   logic [STALL_W-1:0] stall_cnt;

   assign in_raw = {digit, display};

   // in_change is "the next in_q differs from this one", so stable_cnt always
   // describes the value currently held in in_q; it reads SETTLE_LAST on the
   // SETTLE_CYCLES-th consecutive cycle of an unchanged phase.
   assign in_change  = (in_raw != in_q);
   assign settled    = (stable_cnt == SETTLE_LAST) && !sampled;
   assign dig_valid  = dig_one_low(in_q.digit);
   assign dig_multi  = !dig_valid && (in_q.digit != DIG_IDLE);
   assign sample     = settled && dig_valid;
   assign sample_idx = dig_index(in_q.digit);
   assign frame_done = (collected == 4'hF);

   seg7_decode u_decode (
      .seg      (in_q.display),
      .nibble   (dec_nib),
      .is_blank (dec_blank),
      .is_err   (dec_err)
   );

   // Input capture and settle tracking; one sample opportunity per phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q       <= '0;
         stable_cnt <= '0;
         sampled    <= 1'b0;
      end else begin
         in_q <= in_raw;
         if (in_change) begin
            stable_cnt <= '0;
            sampled    <= 1'b0;
         end else begin
            if (stable_cnt != 8'hFF) begin
               stable_cnt <= stable_cnt + 8'd1;
            end
            if (settled) begin
               sampled <= 1'b1;
            end
         end
      end
   end

   // Per-digit compare of the assembled frame against the driver's word.
   always_comb begin
      nib_miss = '0;
      for (int i = 0; i < 4; i++) begin
         nib_miss[i] = !nib_match(expected[4*i +: 4], frame_nib[4*i +: 4], frame_blank[i]);
      end
   end

   // Frame assembly; a sample arriving as a frame completes starts the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_nib   <= '0;
         frame_blank <= '0;
         collected   <= '0;
      end else begin
         if (frame_done) begin
            collected <= '0;
         end
         if (sample) begin
            frame_nib[{sample_idx, 2'b00} +: 4] <= dec_nib;
            frame_blank[sample_idx]             <= dec_blank;
            collected[sample_idx]               <= 1'b1;
         end
      end
   end

   // Registered results and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nums_out    <= '0;
         blank_mask  <= '0;
         frame_valid <= 1'b0;
         mismatch    <= 1'b0;
         seg_err     <= 1'b0;
         digit_err   <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         if (frame_done) begin
            nums_out   <= frame_nib;
            blank_mask <= frame_blank;
            mismatch   <= |nib_miss;
         end
         if (sample && dec_err) begin
            seg_err <= 1'b1;
         end
         if (settled && dig_multi) begin
            digit_err <= 1'b1;
         end
      end
   end

   // Cycles since the last accepted sample, saturating at the stall threshold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (sample) begin
         stall_cnt <= '0;
      end else if (stall_cnt != STALL_MAX) begin
         stall_cnt <= stall_cnt + STALL_ONE;
      end
   end

   assign stalled = (stall_cnt == STALL_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table-driven scan frames with a scoreboard of
// expected frame results, plus hand-written settle, stall, error and reset
// sequences.
module tb_seg_scan_decoder;
   import seg_pkg::*;

   localparam int SETTLE = 4;
   localparam int STALL  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  digit;
   logic [6:0]  display;
   logic [15:0] expected;
   logic [15:0] nums_out;
   logic [3:0]  blank_mask;
   logic        frame_valid;
   logic        mismatch;
   logic        seg_err;
   logic        digit_err;
   logic        stalled;

   seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .STALL_CYCLES(STALL)) dut (
      .clk         (clk),
      .rst         (rst),
      .digit       (digit),
      .display     (display),
      .expected    (expected),
      .nums_out    (nums_out),
      .blank_mask  (blank_mask),
      .frame_valid (frame_valid),
      .mismatch    (mismatch),
      .seg_err     (seg_err),
      .digit_err   (digit_err),
      .stalled     (stalled)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] nums;
      logic [3:0]  blank;
      logic        mm;
   } exp_t;

   typedef struct {
      logic [6:0]  s3, s2, s1, s0;
      logic [15:0] exp_word;
      logic [15:0] nums;
      logic [3:0]  blank;
      logic        mm;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   fv_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic phase(input logic [3:0] d, input logic [6:0] s, input int n);
      digit   = d;
      display = s;
      tick(n);
   endtask

   task automatic push(input logic [15:0] nums, input logic [3:0] blank, input logic mm);
      exp_t e;
      e.nums  = nums;
      e.blank = blank;
      e.mm    = mm;
      sb.push_back(e);
   endtask

   // Scoreboard: every frame_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && frame_valid) begin
         fv_count++;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got nums_out %0h, wanted no frame", nums_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("frame_nums", 32'(nums_out), 32'(e.nums));
            chk("frame_blank", 32'(blank_mask), 32'(e.blank));
            chk("frame_mismatch", 32'(mismatch), 32'(e.mm));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, wanted end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic prev_mm;
      int   fv_before;
      int   budget;

      vecs[0] = '{SEG_3, SEG_2, SEG_1, SEG_0, 16'h3210, 16'h3210, 4'b0000, 1'b0};
      vecs[1] = '{SEG_9, SEG_8, SEG_7, SEG_6, 16'h9876, 16'h9876, 4'b0000, 1'b0};
      vecs[2] = '{SEG_BLANK, SEG_5, SEG_BLANK, SEG_2, 16'hF5A2, 16'hF5F2, 4'b1010, 1'b0};
      vecs[3] = '{SEG_BLANK, SEG_5, SEG_BLANK, SEG_3, 16'hF5A2, 16'hF5F3, 4'b1010, 1'b1};
      vecs[4] = '{SEG_1, SEG_2, SEG_3, SEG_BLANK, 16'h1234, 16'h123F, 4'b0001, 1'b1};
      vecs[5] = '{SEG_0, SEG_0, SEG_0, SEG_0, 16'h0000, 16'h0000, 4'b0000, 1'b0};
      vecs[6] = '{SEG_4, SEG_9, SEG_8, SEG_7, 16'h4B87, 16'h4987, 4'b0000, 1'b1};

      rst      = 1'b1;
      digit    = DIG_IDLE;
      display  = SEG_BLANK;
      expected = 16'h0000;
      tick(3);
      chk("reset_nums", 32'(nums_out), 32'h0);
      chk("reset_blank", 32'(blank_mask), 32'h0);
      chk("reset_flags", 32'({frame_valid, mismatch, seg_err, digit_err, stalled}), 32'h0);
      rst = 1'b0;
      tick(1);

      // Table-driven clean scans, order digit0..digit3.
      prev_mm = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("mismatch_hold", 32'(mismatch), 32'(prev_mm));
         expected = vecs[i].exp_word;
         push(vecs[i].nums, vecs[i].blank, vecs[i].mm);
         phase(DIG0, vecs[i].s0, 10);
         phase(DIG1, vecs[i].s1, 10);
         phase(DIG2, vecs[i].s2, 10);
         phase(DIG3, vecs[i].s3, 10);
         prev_mm = vecs[i].mm;
      end
      chk("queue_after_table", 32'(sb.size()), 32'h0);

      // Settle boundary: SETTLE-1 cycles never samples, exactly SETTLE does,
      // and a very long phase samples only once.
      expected = 16'h8761;
      phase(DIG0, SEG_5, SETTLE - 1);
      phase(DIG1, SEG_6, 10);
      phase(DIG2, SEG_7, 10);
      phase(DIG3, SEG_8, SETTLE);
      phase(DIG_IDLE, SEG_BLANK, 20);
      fv_before = fv_count;
      push(16'h8761, 4'b0000, 1'b0);
      phase(DIG0, SEG_1, 20);
      chk("stall_before_limit", 32'(stalled), 32'h0);
      tick(1);
      chk("stall_at_limit", 32'(stalled), 32'h1);
      tick(979);
      chk("long_phase_stalled", 32'(stalled), 32'h1);
      chk("long_phase_one_frame", 32'(fv_count - fv_before), 32'h1);

      // Idle keeps stalled high; the next sample clears it one cycle later.
      phase(DIG_IDLE, SEG_BLANK, 20);
      chk("idle_stalled", 32'(stalled), 32'h1);
      phase(DIG1, SEG_2, SETTLE);
      chk("stall_at_sample", 32'(stalled), 32'h1);
      tick(1);
      chk("stall_cleared", 32'(stalled), 32'h0);
      tick(5);

      // Two anodes low, then an undecodable pattern; digit1 is rescanned so the
      // later sample must replace the one captured above.
      expected = 16'h0994;
      phase(4'b1001, SEG_8, 20);
      chk("digit_err_set", 32'(digit_err), 32'h1);
      chk("seg_err_clear", 32'(seg_err), 32'h0);
      push(16'h0F94, 4'b0000, 1'b1);
      phase(DIG2, 7'b0101010, 10);
      phase(DIG0, SEG_4, 10);
      phase(DIG1, SEG_9, 10);
      phase(DIG3, SEG_0, 10);
      chk("seg_err_set", 32'(seg_err), 32'h1);

      expected = 16'h3210;
      push(16'h3210, 4'b0000, 1'b0);
      phase(DIG0, SEG_0, 10);
      phase(DIG1, SEG_1, 10);
      phase(DIG2, SEG_2, 10);
      phase(DIG3, SEG_3, 10);
      chk("seg_err_sticky", 32'(seg_err), 32'h1);
      chk("digit_err_sticky", 32'(digit_err), 32'h1);

      // Reset with half a frame collected.
      expected = 16'h6587;
      phase(DIG0, SEG_1, 10);
      phase(DIG1, SEG_2, 10);
      rst = 1'b1;
      tick(2);
      chk("midrst_nums", 32'(nums_out), 32'h0);
      chk("midrst_blank", 32'(blank_mask), 32'h0);
      chk("midrst_flags", 32'({frame_valid, mismatch, seg_err, digit_err, stalled}), 32'h0);
      rst = 1'b0;
      phase(DIG2, SEG_5, 10);
      phase(DIG3, SEG_6, 10);
      chk("midrst_no_frame", 32'(nums_out), 32'h0);
      push(16'h6587, 4'b0000, 1'b0);
      phase(DIG0, SEG_7, 10);
      phase(DIG1, SEG_8, 10);
      chk("midrst_frame_nums", 32'(nums_out), 32'h6587);
      chk("midrst_sticky_cleared", 32'({seg_err, digit_err}), 32'h0);

      phase(DIG_IDLE, SEG_BLANK, 1);
      budget = 100;
      while (sb.size() != 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
